// File: rtl/note_scheduler_pkg.sv
// Shared types and ROM entry field positions for the note scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package note_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_FREE  = 3'd5
  } state_t;

  // Song ROM entry layout: [15:8] note, [7:6] octave, [5:0] duration units
  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 8;
  localparam int OCT_MSB  = 7;
  localparam int OCT_LSB  = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

endpackage

// File: rtl/note_scheduler_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV cycles after reset release.
// Backpressure: none; the tick cannot be stalled.
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick = (count_q == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Song autoplay sequencer with free-play key override and pause/resume.
// Latency: play -> busy next cycle; ROM entry sounds 3 cycles after play.
// Backpressure: none; play while busy is dropped, stop/key always accepted.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int TICK_DIV       = 100000,
  parameter int DUR_UNIT_TICKS = 50,
  parameter int GAP_TICKS      = 20,
  parameter int KEY_HOLD_TICKS = 200,
  parameter int ROM_AW         = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              key_valid,
  input  logic [7:0]        key_note,
  input  logic [1:0]        key_octave,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        note,
  output logic [1:0]        shift,
  output logic              busy,
  output logic              song_done
);

  localparam logic [ROM_AW-1:0] ADDR_MAX = '1;

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  // cnt_q is left untouched while in FREE, so it doubles as the saved counter
  state_t            state_q, state_d, sv_state_q, sv_state_d;
  logic [31:0]       cnt_q, cnt_d, hold_q, hold_d;
  logic [7:0]        note_q, note_d, ent_note_q, ent_note_d;
  logic [1:0]        shift_q, shift_d, ent_shift_q, ent_shift_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              done_q, done_d, paused_q, paused_d;

  logic [7:0] rom_note;
  logic [1:0] rom_oct;
  logic [5:0] rom_dur;

  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_oct   = rom_data[OCT_MSB:OCT_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];

  assign rom_addr  = addr_q;
  assign note      = note_q;
  assign shift     = shift_q;
  assign song_done = done_q;
  assign busy      = (state_q != S_IDLE) && ((state_q != S_FREE) || paused_q);

  // Next-state and output decode; stop beats key, key beats everything else
  always_comb begin
    state_d     = state_q;
    sv_state_d  = sv_state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    note_d      = note_q;
    shift_d     = shift_q;
    ent_note_d  = ent_note_q;
    ent_shift_d = ent_shift_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    paused_d    = paused_q;
    if (stop) begin
      state_d  = S_IDLE;
      note_d   = '0;
      shift_d  = '0;
      addr_d   = '0;
      paused_d = 1'b0;
    end else if (key_valid && (key_note != 8'd0)) begin
      note_d  = key_note;
      shift_d = key_octave;
      hold_d  = 32'(KEY_HOLD_TICKS);
      state_d = S_FREE;
      // Only an active song is paused; a key in FREE keeps the existing save
      if ((state_q != S_IDLE) && (state_q != S_FREE)) begin
        paused_d   = 1'b1;
        sv_state_d = state_q;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_dur == 6'd0) begin
            note_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            note_d      = rom_note;
            shift_d     = rom_oct;
            ent_note_d  = rom_note;
            ent_shift_d = rom_oct;
            cnt_d       = 32'(rom_dur) * 32'(DUR_UNIT_TICKS);
            state_d     = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (cnt_q <= 32'd1) begin
              note_d  = '0;
              cnt_d   = 32'(GAP_TICKS);
              state_d = S_GAP;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (cnt_q <= 32'd1) begin
              if (addr_q == ADDR_MAX) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = S_FETCH;
              end
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        S_FREE: begin
          if (tick) begin
            if (hold_q <= 32'd1) begin
              note_d = '0;
              if (paused_q) begin
                paused_d = 1'b0;
                state_d  = sv_state_q;
                if (sv_state_q == S_PLAY) begin
                  note_d  = ent_note_q;
                  shift_d = ent_shift_q;
                end
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              hold_d = hold_q - 32'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sv_state_q  <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      note_q      <= '0;
      shift_q     <= '0;
      ent_note_q  <= '0;
      ent_shift_q <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sv_state_q  <= sv_state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      note_q      <= note_d;
      shift_q     <= shift_d;
      ent_note_q  <= ent_note_d;
      ent_shift_q <= ent_shift_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      paused_q    <= paused_d;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a note-segment scoreboard.
// Latency: segments are scored when the sounding note changes.
// Backpressure: n/a.
module tb_note_scheduler;

  typedef struct packed {
    logic [7:0] note;
    logic [1:0] shift;
    logic [7:0] ticks;
  } seg_t;

  logic        clk;
  logic        rst_n;
  logic        play, stop, key_valid;
  logic [7:0]  key_note;
  logic [1:0]  key_octave;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  note;
  logic [1:0]  shift;
  logic        busy, song_done;

  logic [15:0] rom [4];

  int   n_cmp  = 0;
  int   n_fail = 0;
  seg_t exp_q[$];

  // Monitor state
  logic       sb_on;
  logic [7:0] seg_note;
  logic [1:0] seg_shift;
  int         seg_ticks;
  logic       last_tick;
  int         done_cnt;
  logic       wrapped;
  logic [1:0] prev_addr;
  logic [1:0] pc;
  int         d0;

  note_scheduler #(
    .TICK_DIV       (4),
    .DUR_UNIT_TICKS (2),
    .GAP_TICKS      (1),
    .KEY_HOLD_TICKS (3),
    .ROM_AW         (2)
  ) dut (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .play       (play),
    .stop       (stop),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .key_octave (key_octave),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .shift      (shift),
    .busy       (busy),
    .song_done  (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered song ROM, one-cycle read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference tick phase: a tick in every 4th cycle after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 2'd0;
    else        pc <= pc + 2'd1;
  end

  function automatic seg_t mk(input logic [7:0] n, input logic [1:0] s, input logic [7:0] t);
    seg_t r;
    r.note  = n;
    r.shift = s;
    r.ticks = t;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Segment tracker: counts ticks while a note sounds, scores it when it ends
  initial begin
    seg_note  = 8'd0;
    seg_shift = 2'd0;
    seg_ticks = 0;
    last_tick = 1'b0;
    done_cnt  = 0;
    wrapped   = 1'b0;
    prev_addr = 2'd0;
    forever begin
      @(negedge clk);
      last_tick = (pc == 2'd3);
      if (song_done === 1'b1) done_cnt++;
      if (busy === 1'b1 && prev_addr == 2'd3 && rom_addr == 2'd0) wrapped = 1'b1;
      prev_addr = rom_addr;
      if ({note, shift} != {seg_note, seg_shift}) begin
        if (seg_note != 8'd0 && sb_on) begin
          if (exp_q.size() == 0) begin
            check("segment_extra", {14'd0, seg_note, seg_shift, seg_ticks[7:0]}, 32'd0);
          end else begin
            check("segment", {14'd0, seg_note, seg_shift, seg_ticks[7:0]}, {14'd0, exp_q.pop_front()});
          end
        end
        seg_note  = note;
        seg_shift = shift;
        seg_ticks = last_tick ? 1 : 0;
      end else begin
        seg_ticks += last_tick ? 1 : 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_seg(input logic [7:0] n, input int t);
    int k = 0;
    while (!(seg_note == n && seg_ticks == t && last_tick) && k < 400) begin
      step();
      k++;
    end
    check("wait_seg", {31'd0, (k < 400)}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_key(input logic [7:0] n, input logic [1:0] o);
    key_valid  = 1'b1;
    key_note   = n;
    key_octave = o;
    step();
    key_valid  = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic load_song1();
    rom[0] = 16'h2142;
    rom[1] = 16'h3003;
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b1; play = 1'b0; stop = 1'b0; key_valid = 1'b0;
    key_note = 8'd0; key_octave = 2'd0; sb_on = 1'b1;
    load_song1();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_note", {24'd0, note}, 32'd0);
    check("rst_shift", {30'd0, shift}, 32'd0);
    check("rst_addr", {30'd0, rom_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, song_done}, 32'd0);
    rst_n = 1'b1;
    step();

    // Plain autoplay; a second play while busy and a zero-note key are ignored
    d0 = done_cnt;
    exp_q.push_back(mk(8'h21, 2'd1, 8'd4));
    exp_q.push_back(mk(8'h30, 2'd0, 8'd6));
    check("busy_pre", {31'd0, busy}, 32'd0);
    pulse_play();
    check("busy_rise", {31'd0, busy}, 32'd1);
    step();
    pulse_play();
    wait_seg(8'h30, 1);
    step();
    pulse_key(8'h00, 2'd3);
    wait_idle(400);
    check("t1_done", done_cnt - d0, 32'd1);
    check("t1_queue", exp_q.size(), 32'd0);
    check("t1_note", {24'd0, note}, 32'd0);

    // Key interrupts PLAY with 2 ticks left, then the song resumes
    d0 = done_cnt;
    exp_q.push_back(mk(8'h21, 2'd1, 8'd2));
    exp_q.push_back(mk(8'h15, 2'd2, 8'd3));
    exp_q.push_back(mk(8'h21, 2'd1, 8'd2));
    exp_q.push_back(mk(8'h30, 2'd0, 8'd6));
    pulse_play();
    wait_seg(8'h21, 2);
    step();
    pulse_key(8'h15, 2'd2);
    check("t2_paused_busy", {31'd0, busy}, 32'd1);
    wait_idle(400);
    check("t2_done", done_cnt - d0, 32'd1);
    check("t2_queue", exp_q.size(), 32'd0);

    // Free play from idle, with a re-strike replacing the held note
    d0 = done_cnt;
    exp_q.push_back(mk(8'h05, 2'd3, 8'd1));
    exp_q.push_back(mk(8'h06, 2'd1, 8'd3));
    while (!last_tick) step();
    step();
    pulse_key(8'h05, 2'd3);
    check("t3_busy", {31'd0, busy}, 32'd0);
    wait_seg(8'h05, 1);
    step();
    pulse_key(8'h06, 2'd1);
    for (int k = 0; k < 200 && note != 8'd0; k++) step();
    check("t3_silent", {24'd0, note}, 32'd0);
    check("t3_queue", exp_q.size(), 32'd0);
    check("t3_done", done_cnt - d0, 32'd0);

    // stop and key in the same cycle mid-song
    sb_on = 1'b0;
    d0 = done_cnt;
    pulse_play();
    wait_seg(8'h21, 1);
    step();
    stop = 1'b1;
    pulse_key(8'h15, 2'd2);
    stop = 1'b0;
    check("t4_note", {24'd0, note}, 32'd0);
    check("t4_shift", {30'd0, shift}, 32'd0);
    check("t4_addr", {30'd0, rom_addr}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    repeat (40) step();
    check("t4_note_later", {24'd0, note}, 32'd0);
    check("t4_done", done_cnt - d0, 32'd0);
    sb_on = 1'b1;

    // Four-entry song runs to the last address without wrapping
    rom[0] = 16'h1041;
    rom[1] = 16'h1182;
    rom[2] = 16'h12C1;
    rom[3] = 16'h1301;
    d0 = done_cnt;
    exp_q.push_back(mk(8'h10, 2'd1, 8'd2));
    exp_q.push_back(mk(8'h11, 2'd2, 8'd4));
    exp_q.push_back(mk(8'h12, 2'd3, 8'd2));
    exp_q.push_back(mk(8'h13, 2'd0, 8'd2));
    pulse_play();
    wait_idle(600);
    repeat (3) step();
    check("t5_done", done_cnt - d0, 32'd1);
    check("t5_wrap", {31'd0, wrapped}, 32'd0);
    check("t5_queue", exp_q.size(), 32'd0);
    check("t5_addr", {30'd0, rom_addr}, 32'd3);
    check("t5_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-note, then a fresh song from address 0
    load_song1();
    sb_on = 1'b0;
    pulse_play();
    wait_seg(8'h21, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_note", {24'd0, note}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_addr", {30'd0, rom_addr}, 32'd0);
    check("t6_done", {31'd0, song_done}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    sb_on = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(mk(8'h21, 2'd1, 8'd4));
    exp_q.push_back(mk(8'h30, 2'd0, 8'd6));
    pulse_play();
    wait_idle(400);
    check("t6_restart_done", done_cnt - d0, 32'd1);
    check("t6_restart_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning sys_clk cycles per timing tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter DUR_UNIT_TICKS, default 50, meaning ticks per song-entry duration unit.
REQ-003 SHALL have parameter GAP_TICKS, default 20, meaning silent ticks inserted between song entries.
REQ-004 SHALL have parameter KEY_HOLD_TICKS, default 200, meaning ticks a free-play note sounds after its last strobe.
REQ-005 SHALL have parameter ROM_AW, default 8, meaning song ROM address width.
REQ-006 SHALL have port sys_clk, input, 1, the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port play, input, 1, single-cycle start-autoplay pulse.
REQ-009 SHALL have port stop, input, 1, single-cycle abort pulse.
REQ-010 SHALL have port key_valid, input, 1, single-cycle free-play key strobe.
REQ-011 SHALL have port key_note, input, 8, free-play note code; 0 means no note.
REQ-012 SHALL have port key_octave, input, 2, free-play octave shift.
REQ-013 SHALL have port rom_addr, output, ROM_AW, song ROM address.
REQ-014 SHALL have port rom_data, input, 16, ROM entry: [15:8] note (0 = rest), [7:6] octave, [5:0] duration units (0 = end of song); registered, 1-cycle read latency.
REQ-015 SHALL have port note, output, 8, note code to the sound generator.
REQ-016 SHALL have port shift, output, 2, octave shift to the sound generator.
REQ-017 SHALL have port busy, output, 1, high while autoplay is active or paused.
REQ-018 SHALL have port song_done, output, 1, single-cycle pulse at song end.

Function
REQ-019 SHALL use states IDLE, FETCH, LOAD, PLAY, GAP, FREE; FREE carries a paused flag plus saved state/counter.
REQ-020 SHALL produce a tick strobe every TICK_DIV cycles from a free-running prescaler.
REQ-021 IDLE + play: rom_addr<=0, go FETCH; busy rises the following cycle.
REQ-022 FETCH lasts 1 cycle; LOAD samples rom_data.
REQ-023 LOAD with duration 0: note<=0, song_done pulses 1 cycle, go IDLE.
REQ-024 LOAD with duration d>0: note<=entry note, shift<=entry octave, counter<=d*DUR_UNIT_TICKS, go PLAY.
REQ-025 PLAY decrements on tick; on the tick taking counter to 0: note<=0, counter<=GAP_TICKS, go GAP.
REQ-026 GAP decrements on tick; at 0: rom_addr+1 and FETCH; if rom_addr is 2^ROM_AW-1, go IDLE with song_done pulse (no wrap).
REQ-027 key_valid with key_note!=0 in any state: note<=key_note, shift<=key_octave, hold<=KEY_HOLD_TICKS, go FREE; if autoplay active, save state and counter, set paused.
REQ-028 key_valid with key_note=0 SHALL be ignored.
REQ-029 key_valid in FREE restarts hold with the new note.
REQ-030 FREE hold expiry (tick to 0): note<=0; if paused, restore saved state/counter (note/shift restored from held entry if PLAY); else IDLE.
REQ-031 stop in any state: next cycle IDLE, note=0, shift=0, rom_addr=0, busy=0, paused cleared, no song_done.
REQ-032 Simultaneity priority: stop > key_valid > play; play while busy ignored.
REQ-033 Paused counters SHALL NOT decrement.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, note=0, shift=0, rom_addr=0, busy=0, song_done=0, prescaler/counters=0, paused=0; mid-song reset discards progress.

Structure
REQ-035 Shared package SHALL hold the state enum and ROM field positions (NOTE_MSB/LSB, OCT_MSB/LSB, DUR_MSB/LSB).
REQ-036 Prescaler SHALL be sub-module tick_gen (TICK_DIV parameter, tick output).

Verification (TICK_DIV=4, DUR_UNIT_TICKS=2, GAP_TICKS=1, KEY_HOLD_TICKS=3, ROM_AW=2)
REQ-037 ROM {0x2140 -> note 0x21 oct1 dur0? no: 0x2142, 0x3003, 0x0000}; play -> note 0x21 shift1 for 4 ticks, 0 for 1 tick, note 0x30 for 6 ticks, gap, song_done once, busy 0.
REQ-038 Key 0x15 oct2 during PLAY of 0x21 with 2 ticks left -> note 0x15 for 3 ticks, then 0x21 resumes for exactly 2 ticks.
REQ-039 stop and key_valid same cycle mid-song -> IDLE, note 0, rom_addr 0, no song_done.
REQ-040 All four ROM entries nonzero duration -> after addr 3 gap, song_done, IDLE, rom_addr never wraps to 0 during play.
REQ-041 rst_n low during PLAY (asynchronous, mid-cycle) -> note 0, busy 0 immediately; play afterwards restarts at addr 0.
